// File: rtl/cmd_seq_pkg.sv
// -----------------------------------------------------------------------------
// cmd_seq_pkg
// Shared types and constants for the cmd_seq_player command producer.
//   state_t           : playback state machine encoding
//   CMD_CAL           : full calibrate command word
//   CMD_MOVE          : upper-nibble opcode for a plain move
//   CMD_MOVE_FANFARE  : upper-nibble opcode for a move with fanfare
// -----------------------------------------------------------------------------
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DONE
    } state_t;

    localparam logic [15:0] CMD_CAL          = 16'h0000;
    localparam logic [3:0]  CMD_MOVE         = 4'h2;
    localparam logic [3:0]  CMD_MOVE_FANFARE = 4'h3;

endpackage

// File: rtl/cmd_seq_player_if.sv
// -----------------------------------------------------------------------------
// cmd_seq_player_if
// Host load/control signals plus the cmd_proc command handshake.
//   master : the player (drives cmd, cmd_rdy, status outputs)
//   slave  : host + cmd_proc side (drives load, go/abort, clr_cmd_rdy, send_resp)
// Signals:
//   ld_cmd[15:0], ld_vld, full      : FIFO load port
//   go, abort                       : playback control
//   cmd[15:0], cmd_rdy              : command presented to cmd_proc
//   clr_cmd_rdy, send_resp          : accept / finish from cmd_proc
//   busy, done, err, cmpl_cnt       : playback status
// -----------------------------------------------------------------------------
interface cmd_seq_player_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [15:0]   ld_cmd;
    logic          ld_vld;
    logic          full;
    logic          go;
    logic          abort;
    logic [15:0]   cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic          send_resp;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] cmpl_cnt;

    modport master (
        input  ld_cmd, ld_vld, go, abort, clr_cmd_rdy, send_resp,
        output full, cmd, cmd_rdy, busy, done, err, cmpl_cnt
    );

    modport slave (
        output ld_cmd, ld_vld, go, abort, clr_cmd_rdy, send_resp,
        input  full, cmd, cmd_rdy, busy, done, err, cmpl_cnt
    );

endinterface

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// DEPTH x WIDTH synchronous FIFO holding queued commands.
//   clk, rst        : clock, asynchronous active-high reset
//   i_wr_en/i_wr_data : enqueue (dropped while full)
//   i_rd_en         : pop head
//   i_flush         : empty the FIFO (wins over write and read)
//   o_full/o_empty  : status flags
//   o_level         : entries currently held
//   o_head          : entry at the read pointer
//   o_head_next     : entry that becomes head after a pop this cycle
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    input  logic                    i_flush,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic [WIDTH-1:0]        o_head,
    output logic [WIDTH-1:0]        o_head_next
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;
    logic [AW-1:0]    w_rd_idx_next;

    assign w_wr = i_wr_en && !o_full && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    always_comb begin
        o_level       = r_wr_ptr - r_rd_ptr;
        o_empty       = (r_wr_ptr == r_rd_ptr);
        // Same index with differing wrap bit means the writer lapped the reader.
        o_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_rd_idx_next = r_rd_ptr[AW-1:0] + AW'(1);
        o_head        = r_mem[r_rd_ptr[AW-1:0]];
        // With a single entry left, the successor can only be the word being
        // written this cycle, so forward it instead of reading the array.
        o_head_next   = (o_level > (AW+1)'(1)) ? r_mem[w_rd_idx_next] : i_wr_data;
    end

endmodule

// File: rtl/cmd_seq_player.sv
// -----------------------------------------------------------------------------
// cmd_seq_player
// Host-side producer for the cmd_proc command interface. Queued commands are
// presented one at a time on cmd/cmd_rdy; each is retired by send_resp after
// cmd_proc has cleared cmd_rdy. A missing response within TIMEOUT_CLKS clocks
// of the clear sets err and flushes the queue.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : cmd_seq_player_if master (load, control, handshake, status)
// -----------------------------------------------------------------------------
module cmd_seq_player
    import cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TIMEOUT_CLKS = 2**24
) (
    input  logic               clk,
    input  logic               rst,
    cmd_seq_player_if.master   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_cmd;
    logic          r_err;
    logic [AW:0]   r_cmpl_cnt;
    logic [TW-1:0] r_to_cnt;

    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_level;
    logic [15:0]   w_head;
    logic [15:0]   w_head_next;
    logic          w_wr_fire;
    logic          w_more;
    logic          w_start;
    logic          w_complete;
    logic          w_timeout;
    logic          w_flush;

    assign w_wr_fire = bus.ld_vld && !w_full;
    // Queue still holds work after the pop: a second entry, or an append
    // landing in the same cycle as the pop of the last one.
    assign w_more    = (w_level > (AW+1)'(1)) || w_wr_fire;
    assign w_flush   = bus.abort || w_timeout;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (bus.ld_vld),
        .i_wr_data   (bus.ld_cmd),
        .i_rd_en     (w_complete),
        .i_flush     (w_flush),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level),
        .o_head      (w_head),
        .o_head_next (w_head_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start    = '0;
        w_complete = '0;
        w_timeout  = '0;
        if (bus.abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                // DONE accepts go like IDLE so a go in the done cycle is not lost.
                IDLE, DONE: begin
                    w_next = IDLE;
                    if (bus.go) begin
                        w_start = '1;
                        w_next  = w_empty ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.clr_cmd_rdy) begin
                        if (bus.send_resp) w_complete = '1;
                        else               w_next     = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.send_resp) begin
                        w_complete = '1;
                    end else if (r_to_cnt == TO_LAST) begin
                        w_timeout = '1;
                        w_next    = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
            if (w_complete) w_next = w_more ? ISSUE : DONE;
        end
    end

    always_comb begin
        bus.busy    = (r_state == ISSUE) || (r_state == WAIT_RESP);
        bus.cmd_rdy = (r_state == ISSUE);
        bus.done    = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd      <= '0;
            r_err      <= '0;
            r_cmpl_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            if (bus.abort) begin
                r_err      <= '0;
                r_cmpl_cnt <= '0;
            end else begin
                if (w_start) begin
                    r_err      <= '0;
                    r_cmpl_cnt <= '0;
                    if (!w_empty) r_cmd <= w_head;
                end
                if (w_timeout) r_err <= '1;
                if (w_complete) begin
                    if (r_cmpl_cnt < CNT_MAX) r_cmpl_cnt <= r_cmpl_cnt + (AW+1)'(1);
                    if (w_more) r_cmd <= w_head_next;
                end
            end
            // Held at zero while a command is presented, so it starts from
            // zero on the clock that accepts clr_cmd_rdy.
            if (r_state == ISSUE)          r_to_cnt <= '0;
            else if (r_state == WAIT_RESP) r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign bus.cmd      = r_cmd;
    assign bus.full     = w_full;
    assign bus.err      = r_err;
    assign bus.cmpl_cnt = r_cmpl_cnt;

endmodule
